// File: rtl/glide_scheduler_if.sv
// Bus bundle for glide_scheduler: note writes, key state, glide control and voice frequency outputs.
// master drives the control inputs, slave is the scheduler itself.
interface glide_scheduler_if;
   logic        Enable;
   logic        tick;
   logic        note_wr;
   logic [1:0]  note_voice;
   logic [15:0] note_freq;
   logic [3:0]  key_on;
   logic [15:0] glider;
   logic [15:0] freq0;
   logic [15:0] freq1;
   logic [15:0] freq2;
   logic [15:0] freq3;
   logic        busy;
   logic        done;
   logic        overrun;

   modport master (
      output Enable, tick, note_wr, note_voice, note_freq, key_on, glider,
      input  freq0, freq1, freq2, freq3, busy, done, overrun
   );

   modport slave (
      input  Enable, tick, note_wr, note_voice, note_freq, key_on, glider,
      output freq0, freq1, freq2, freq3, busy, done, overrun
   );
endinterface

// File: rtl/glide_scheduler.sv
// Four-voice portamento scheduler: each tick walks the voices one per cycle, moving each
// current frequency toward its target by a shared step without ever overshooting or wrapping.
module glide_scheduler (
   input  logic             CLK,
   input  logic             RESET,
   glide_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] tgt_q [4];
   logic [15:0] tgt_d [4];
   logic [15:0] cur_q [4];
   logic [15:0] cur_d [4];
   logic [3:0]  kprev_q, kprev_d;
   logic        overrun_q, overrun_d;
   logic        busy;
   logic [15:0] step_val [4];

   // Per-voice step result, evaluated for all voices; only voice idx_q is committed.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_voice
         logic        cur_above;
         logic [15:0] diff;
         logic [15:0] moved;
         logic [15:0] nxt;

         assign cur_above = cur_q[gi] > tgt_q[gi];
         assign diff      = cur_above ? (cur_q[gi] - tgt_q[gi]) : (tgt_q[gi] - cur_q[gi]);
         // Only used when diff > glider, so neither direction can leave the range.
         assign moved     = cur_above ? (cur_q[gi] - bus.glider) : (cur_q[gi] + bus.glider);

         always_comb begin
            nxt = cur_q[gi];
            if (bus.key_on[gi]) begin
               if (!kprev_q[gi] || (bus.glider == 16'd0) || (diff <= bus.glider)) begin
                  nxt = tgt_q[gi];
               end else begin
                  nxt = moved;
               end
            end
         end

         assign step_val[gi] = nxt;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= IDLE;
         idx_q     <= 2'd0;
         kprev_q   <= 4'd0;
         overrun_q <= 1'b0;
         for (int v = 0; v < 4; v++) begin
            tgt_q[v] <= 16'd0;
            cur_q[v] <= 16'd0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         kprev_q   <= kprev_d;
         overrun_q <= overrun_d;
         for (int v = 0; v < 4; v++) begin
            tgt_q[v] <= tgt_d[v];
            cur_q[v] <= cur_d[v];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.tick && bus.Enable) begin
               state_d = SCAN;
               idx_d   = 2'd0;
            end
         end
         SCAN: begin
            if (!bus.Enable) begin
               state_d = IDLE;
               idx_d   = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Voice step reads tgt_q, so a same-cycle note write only takes effect on the next scan.
   always_comb begin
      for (int v = 0; v < 4; v++) begin
         tgt_d[v] = tgt_q[v];
         cur_d[v] = cur_q[v];
      end
      kprev_d   = kprev_q;
      overrun_d = overrun_q | (bus.tick & busy);

      if (bus.note_wr) begin
         tgt_d[bus.note_voice] = bus.note_freq;
      end

      if (!bus.Enable) begin
         for (int v = 0; v < 4; v++) begin
            cur_d[v] = tgt_q[v];
         end
         kprev_d = bus.key_on;
      end else if (state_q == SCAN) begin
         cur_d[idx_q]   = step_val[idx_q];
         kprev_d[idx_q] = bus.key_on[idx_q];
      end
   end

   always_comb begin
      busy        = (state_q != IDLE);
      bus.busy    = busy;
      bus.done    = (state_q == DONE);
      bus.overrun = overrun_q;
      bus.freq0   = bus.Enable ? cur_q[0] : tgt_q[0];
      bus.freq1   = bus.Enable ? cur_q[1] : tgt_q[1];
      bus.freq2   = bus.Enable ? cur_q[2] : tgt_q[2];
      bus.freq3   = bus.Enable ? cur_q[3] : tgt_q[3];
   end

endmodule

// File: tb/tb_glide_scheduler.sv
// Scoreboard bench for glide_scheduler: a behavioural voice model queues expected frequencies
// per scan; a negedge monitor pops and compares them on each done pulse.
module tb_glide_scheduler;

   logic CLK;
   logic RESET;
   glide_scheduler_if bus ();

   glide_scheduler dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] f [4];
   } exp_t;

   exp_t        sb_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   logic [15:0] m_tgt [4];
   logic [15:0] m_cur [4];
   logic [3:0]  m_kprev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] step_f(input logic [15:0] cur, input logic [15:0] tgt,
                                          input logic k, input logic kp, input logic [15:0] g);
      int d;
      if (!k) return cur;
      if (!kp || g == 16'd0) return tgt;
      d = (cur > tgt) ? int'(cur) - int'(tgt) : int'(tgt) - int'(cur);
      if (d <= int'(g)) return tgt;
      return (cur > tgt) ? cur - g : cur + g;
   endfunction

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         m_tgt[v] = 16'd0;
         m_cur[v] = 16'd0;
      end
      m_kprev = 4'd0;
   endtask

   task automatic model_scan();
      exp_t e;
      for (int v = 0; v < 4; v++) begin
         m_cur[v]   = step_f(m_cur[v], m_tgt[v], bus.key_on[v], m_kprev[v], bus.glider);
         m_kprev[v] = bus.key_on[v];
         e.f[v]     = m_cur[v];
      end
      sb_q.push_back(e);
   endtask

   task automatic write_note(input logic [1:0] v, input logic [15:0] f);
      bus.note_voice = v;
      bus.note_freq  = f;
      bus.note_wr    = 1'b1;
      cyc();
      bus.note_wr    = 1'b0;
      m_tgt[v]       = f;
   endtask

   task automatic wait_done();
      int start;
      start = done_cnt;
      for (int i = 0; i < 12; i++) begin
         if (done_cnt != start) break;
         cyc();
      end
      if (done_cnt == start) check("done_timeout", 0, 1);
   endtask

   task automatic run_tick();
      model_scan();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      wait_done();
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RESET === 1'b1 && bus.done === 1'b1) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
         end else begin
            e = sb_q.pop_front();
            $display("scan %0d: freq = %0d %0d %0d %0d (expect %0d %0d %0d %0d)", done_cnt,
                     bus.freq0, bus.freq1, bus.freq2, bus.freq3, e.f[0], e.f[1], e.f[2], e.f[3]);
            check("scan_f0", bus.freq0, e.f[0]);
            check("scan_f1", bus.freq1, e.f[1]);
            check("scan_f2", bus.freq2, e.f[2]);
            check("scan_f3", bus.freq3, e.f[3]);
         end
      end
   end

   initial begin
      int exp_dn [5];
      int d0;
      exp_dn = '{970, 940, 910, 900, 900};

      bus.Enable = 1'b0;
      bus.tick = 1'b0;
      bus.note_wr = 1'b0;
      bus.note_voice = 2'd0;
      bus.note_freq = 16'd0;
      bus.key_on = 4'd0;
      bus.glider = 16'd0;
      model_reset();
      RESET = 1'b1;
      #2 RESET = 1'b0;
      #1;
      check("rst_freq0", bus.freq0, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_overrun", bus.overrun, 0);
      cyc();
      cyc();
      RESET = 1'b1;
      bus.Enable = 1'b1;
      cyc();

      // New press snaps straight to target one edge after the tick
      write_note(2'd0, 16'd1000);
      bus.key_on = 4'b0001;
      model_scan();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      check("snap_pre", bus.freq0, 0);
      cyc();
      check("snap_t0p1", bus.freq0, 1000);
      wait_done();

      write_note(2'd0, 16'd900);
      bus.glider = 16'd30;
      for (int i = 0; i < 5; i++) begin
         run_tick();
         check("glide_down", bus.freq0, exp_dn[i]);
      end

      bus.key_on = 4'b0011;
      write_note(2'd1, 16'd65500);
      run_tick();
      check("up_snap", bus.freq1, 65500);
      write_note(2'd1, 16'd65535);
      bus.glider = 16'd100;
      run_tick();
      check("up_nowrap", bus.freq1, 65535);
      write_note(2'd1, 16'd300);
      bus.glider = 16'd50;
      run_tick();
      check("down_step", bus.freq1, 65485);
      bus.glider = 16'd0;
      run_tick();
      check("g0_snap", bus.freq1, 300);

      // Second tick while busy is dropped; write to voice 2 lands on its own step edge
      bus.key_on = 4'b0111;
      bus.glider = 16'd100;
      write_note(2'd2, 16'd2000);
      run_tick();
      write_note(2'd2, 16'd3000);
      d0 = done_cnt;
      model_scan();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      check("overrun_set", bus.overrun, 1);
      bus.note_voice = 2'd2;
      bus.note_freq = 16'd5000;
      bus.note_wr = 1'b1;
      cyc();
      bus.note_wr = 1'b0;
      m_tgt[2] = 16'd5000;
      wait_done();
      for (int i = 0; i < 6; i++) cyc();
      check("one_done", done_cnt - d0, 1);
      check("coll_old_tgt", bus.freq2, 2100);
      run_tick();
      check("coll_new_tgt", bus.freq2, 2200);

      bus.Enable = 1'b0;
      cyc();
      write_note(2'd3, 16'd500);
      check("byp_freq3", bus.freq3, 500);
      check("byp_freq0", bus.freq0, 900);
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("byp_busy", bus.busy, 0);
         cyc();
      end
      check("overrun_sticky", bus.overrun, 1);
      for (int v = 0; v < 4; v++) m_cur[v] = m_tgt[v];
      m_kprev = bus.key_on;
      bus.Enable = 1'b1;
      cyc();
      check("byp_cur_sync", bus.freq3, 500);

      // Asynchronous reset mid-scan, then a clean scan from voice 0
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
      cyc();
      #2 RESET = 1'b0;
      #1;
      check("mid_rst_freq0", bus.freq0, 0);
      check("mid_rst_freq2", bus.freq2, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_overrun", bus.overrun, 0);
      sb_q.delete();
      model_reset();
      cyc();
      RESET = 1'b1;
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) cyc();
      check("no_done_after_rst", done_cnt - d0, 0);
      model_scan();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
      cyc();
      cyc();
      check("lat_t0p3", bus.done, 0);
      cyc();
      check("lat_t0p4", bus.done, 1);
      cyc();
      check("lat_t0p5", bus.done, 0);
      check("lat_count", done_cnt - d0, 1);

      check("sb_leftover", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
